// File: rtl/tdma_pkg.sv
// Definitions shared by the TDMA ping transmit and receive paths: IPIC
// transfer codes, ping flag values, payload word layout and small helpers.
package tdma_pkg;

    localparam logic [2:0] BURST_RD  = 3'd0;
    localparam logic [2:0] BURST_WR  = 3'd1;
    localparam logic [2:0] SINGLE_RD = 3'd2;
    localparam logic [2:0] SINGLE_WR = 3'd3;

    localparam logic [5:0] FLAG_PING     = 6'd1;
    localparam logic [5:0] FLAG_ACK_PING = 6'd2;

    localparam logic [31:0] MAX_COUNTER2 = 32'hf4239;

    // 32-bit word positions inside the ping payload, lowest word first
    localparam int W_FLAG = 0;
    localparam int W_SEQ  = 1;
    localparam int W_SEC  = 2;
    localparam int W_CNT2 = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CHECK,
        ST_DELIVER
    } rx_state_e;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/tdma_ping_rx_parser_if.sv
// IPIC burst-master request/response bundle; the parser drives the master side,
// the burst arbiter sits on the slave side.
interface tdma_ping_rx_parser_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int C_LENGTH_WIDTH = 14
);
    logic                      ipic_start;
    logic [2:0]                ipic_type;
    logic [ADDR_WIDTH-1:0]     read_addr;
    logic [C_LENGTH_WIDTH-1:0] read_length;
    logic                      ipic_ack;
    logic                      ipic_done_wire;
    logic [1023:0]             bunch_read_data;

    modport master (
        output ipic_start, ipic_type, read_addr, read_length,
        input  ipic_ack, ipic_done_wire, bunch_read_data
    );

    modport slave (
        input  ipic_start, ipic_type, read_addr, read_length,
        output ipic_ack, ipic_done_wire, bunch_read_data
    );
endinterface

// File: rtl/tdma_sync_fifo.sv
// First-word-fall-through synchronous FIFO; rd_dat is valid whenever !empty.
// A write while full is accepted only if a read happens in the same cycle.
module tdma_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  do_wr, do_rd;

    assign full   = (cnt_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign rd_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_rd    = rd_rdy && !empty;
        do_wr    = wr_vld && (!full || do_rd);
        wr_ptr_d = wr_ptr_q + (do_wr ? 1'b1 : 1'b0);
        rd_ptr_d = rd_ptr_q + (do_rd ? 1'b1 : 1'b0);
        cnt_d    = cnt_q;
        if (do_wr && !do_rd) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_dat;
        end
    end

endmodule

// File: rtl/tdma_ping_rx_parser.sv
// Queues completed RX descriptors, burst-reads each 16-byte ping payload and
// hands decoded PING/ACK_PING frames to the ping state machine in arrival order.
module tdma_ping_rx_parser
    import tdma_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          C_LENGTH_WIDTH = 14,
    parameter logic [31:0] PAYLOAD_OFFSET = 32'h50,
    parameter int          PING_LEN       = 16,
    parameter int          QDEPTH_LOG2    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_done,
    input  logic [ADDR_WIDTH-1:0] rx_buf_addr,
    input  logic [15:0]           rx_len,
    tdma_ping_rx_parser_if.master ipic,
    input  logic                  consumer_idle,
    output logic                  recv_ping,
    output logic                  recv_ack_ping,
    output logic [31:0]           recv_seq,
    output logic [31:0]           recv_sec,
    output logic [31:0]           recv_counter2,
    output logic [15:0]           rx_ping_cnt,
    output logic [15:0]           rx_ack_cnt,
    output logic [15:0]           rx_drop_cnt
);
    localparam logic [31:0] MIN_LEN = PAYLOAD_OFFSET + 32'(PING_LEN);
    localparam int          QW      = ADDR_WIDTH + 16;

    rx_state_e                 state_q, state_d;
    logic                      start_q, start_d;
    logic [ADDR_WIDTH-1:0]     read_addr_q, read_addr_d;
    logic [C_LENGTH_WIDTH-1:0] read_len_q, read_len_d;
    logic [5:0]                cap_flag_q, cap_flag_d;
    logic [31:0]               cap_seq_q, cap_seq_d;
    logic [31:0]               cap_sec_q, cap_sec_d;
    logic [31:0]               cap_cnt2_q, cap_cnt2_d;
    logic                      ping_q, ping_d;
    logic                      ack_q, ack_d;
    logic [31:0]               seq_q, seq_d;
    logic [31:0]               sec_q, sec_d;
    logic [31:0]               cnt2_q, cnt2_d;
    logic [15:0]               ping_cnt_q, ping_cnt_d;
    logic [15:0]               ack_cnt_q, ack_cnt_d;
    logic [15:0]               drop_cnt_q, drop_cnt_d;

    logic                  fifo_pop, fifo_full, fifo_empty;
    logic [QW-1:0]         fifo_head;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [15:0]           head_len;
    logic                  deliver, bad_frame, overflow;
    logic                  unused_rd;

    tdma_sync_fifo #(
        .WIDTH      (QW),
        .DEPTH_LOG2 (QDEPTH_LOG2)
    ) u_evt_q (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (rx_done),
        .wr_dat ({rx_buf_addr, rx_len}),
        .rd_rdy (fifo_pop),
        .rd_dat (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign head_addr = fifo_head[QW-1:16];
    assign head_len  = fifo_head[15:0];
    // only the 16-byte payload is meaningful; flag spare bits are ignored
    assign unused_rd = ^{ipic.bunch_read_data[1023:128], ipic.bunch_read_data[31:6]};

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        read_addr_d = read_addr_q;
        read_len_d  = read_len_q;
        cap_flag_d  = cap_flag_q;
        cap_seq_d   = cap_seq_q;
        cap_sec_d   = cap_sec_q;
        cap_cnt2_d  = cap_cnt2_q;
        seq_d       = seq_q;
        sec_d       = sec_q;
        cnt2_d      = cnt2_q;
        ping_d      = 1'b0;
        ack_d       = 1'b0;
        fifo_pop    = 1'b0;
        deliver     = 1'b0;
        bad_frame   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    read_addr_d = head_addr + ADDR_WIDTH'(PAYLOAD_OFFSET);
                    read_len_d  = C_LENGTH_WIDTH'(PING_LEN);
                    if (32'(head_len) < MIN_LEN) begin
                        bad_frame = 1'b1;
                    end else begin
                        start_d = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (ipic.ipic_ack) begin
                    start_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ipic.ipic_done_wire) begin
                    cap_flag_d = ipic.bunch_read_data[W_FLAG*32 +: 6];
                    cap_seq_d  = ipic.bunch_read_data[W_SEQ*32  +: 32];
                    cap_sec_d  = ipic.bunch_read_data[W_SEC*32  +: 32];
                    cap_cnt2_d = ipic.bunch_read_data[W_CNT2*32 +: 32];
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // deliver straight from CHECK when the consumer is already idle
                if (cap_flag_q != FLAG_PING && cap_flag_q != FLAG_ACK_PING) begin
                    bad_frame = 1'b1;
                    state_d   = ST_IDLE;
                end else if (consumer_idle) begin
                    deliver = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (consumer_idle) begin
                    deliver = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (deliver) begin
            seq_d  = cap_seq_q;
            sec_d  = cap_sec_q;
            cnt2_d = cap_cnt2_q;
            ping_d = (cap_flag_q == FLAG_PING);
            ack_d  = (cap_flag_q == FLAG_ACK_PING);
        end

        overflow   = rx_done && fifo_full && !fifo_pop;
        ping_cnt_d = sat_add16(ping_cnt_q, {1'b0, ping_d});
        ack_cnt_d  = sat_add16(ack_cnt_q, {1'b0, ack_d});
        drop_cnt_d = sat_add16(drop_cnt_q, {1'b0, bad_frame} + {1'b0, overflow});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            read_addr_q <= '0;
            read_len_q  <= '0;
            cap_flag_q  <= '0;
            cap_seq_q   <= '0;
            cap_sec_q   <= '0;
            cap_cnt2_q  <= '0;
            ping_q      <= 1'b0;
            ack_q       <= 1'b0;
            seq_q       <= '0;
            sec_q       <= '0;
            cnt2_q      <= '0;
            ping_cnt_q  <= '0;
            ack_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            read_addr_q <= read_addr_d;
            read_len_q  <= read_len_d;
            cap_flag_q  <= cap_flag_d;
            cap_seq_q   <= cap_seq_d;
            cap_sec_q   <= cap_sec_d;
            cap_cnt2_q  <= cap_cnt2_d;
            ping_q      <= ping_d;
            ack_q       <= ack_d;
            seq_q       <= seq_d;
            sec_q       <= sec_d;
            cnt2_q      <= cnt2_d;
            ping_cnt_q  <= ping_cnt_d;
            ack_cnt_q   <= ack_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign ipic.ipic_start  = start_q;
    assign ipic.ipic_type   = BURST_RD;
    assign ipic.read_addr   = read_addr_q;
    assign ipic.read_length = read_len_q;
    assign recv_ping        = ping_q;
    assign recv_ack_ping    = ack_q;
    assign recv_seq         = seq_q;
    assign recv_sec         = sec_q;
    assign recv_counter2    = cnt2_q;
    assign rx_ping_cnt      = ping_cnt_q;
    assign rx_ack_cnt       = ack_cnt_q;
    assign rx_drop_cnt      = drop_cnt_q;

endmodule

// File: doc/tdma_ping_rx_parser.md
Name: tdma_ping_rx_parser

Overview:
- Receive-side counterpart of the TDMA ping/ack-ping transmitter.
- On each completed ath9k RX descriptor, burst-reads the 16-byte ping payload from the RX buffer over the IPIC burst master.
- Decodes flag/seq/utc_sec/counter2 and delivers one-cycle recv_ping / recv_ack_ping pulses plus held fields to the TDMA control block.
- Sits between the RX descriptor IRQ logic and the IPIC burst arbiter (as a third requester) and the ping state machine.

Parameters:
ADDR_WIDTH, 32, IPIC address width
DATA_WIDTH, 32, IPIC data width
C_LENGTH_WIDTH, 14, IPIC burst length width
PAYLOAD_OFFSET, 32'h50, byte offset from RX buffer start to ping payload (48-byte RX status + 30-byte MAC header + 2 pad)
PING_LEN, 16, payload bytes read
QDEPTH_LOG2, 2, pending RX event queue depth = 4

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_done  in  1  one-cycle pulse: RX descriptor completed
rx_buf_addr  in  ADDR_WIDTH  RX buffer physical address, valid with rx_done
rx_len  in  16  frame length in bytes incl. RX status, valid with rx_done
ipic_start  out  1  burst request
ipic_type  out  3  always BURST_RD (0)
read_addr  out  ADDR_WIDTH  burst read address
read_length  out  C_LENGTH_WIDTH  burst length in bytes
ipic_ack  in  1  request accepted
ipic_done_wire  in  1  transfer complete pulse
bunch_read_data  in  1024  burst read data, valid on ipic_done_wire
consumer_idle  in  1  ping state machine is in its idle state
recv_ping  out  1  one-cycle pulse: PING frame decoded
recv_ack_ping  out  1  one-cycle pulse: ACK_PING frame decoded
recv_seq  out  32  decoded sequence number
recv_sec  out  32  decoded UTC seconds
recv_counter2  out  32  decoded timepulse-2 counter
rx_ping_cnt  out  16  PING frames delivered
rx_ack_cnt  out  16  ACK_PING frames delivered
rx_drop_cnt  out  16  frames dropped (short, bad flag, queue overflow)

Behaviour:
- Reset: all outputs 0, queue empty, state IDLE; an IPIC transaction in flight is abandoned, and a later ipic_done_wire is ignored in IDLE.
- Queue: rx_done pushes {rx_buf_addr, rx_len}.
  - Queue full and no pop in the same cycle: event dropped, rx_drop_cnt+1.
  - Simultaneous push and pop while full: push accepted.
- State machine:
  - IDLE: queue non-empty -> pop the head; read_addr = addr + PAYLOAD_OFFSET; read_length = PING_LEN.
    - If len < PAYLOAD_OFFSET + PING_LEN: drop, rx_drop_cnt+1, stay in IDLE.
    - Otherwise go to REQ.
  - REQ: ipic_start = 1 and held. On ipic_ack, deassert ipic_start next cycle -> WAIT.
  - WAIT: on ipic_done_wire, capture bunch_read_data[127:0] -> CHECK.
  - CHECK: word layout, little word first:
    - [5:0] = flag, [31:6] ignored
    - [63:32] = seq
    - [95:64] = sec
    - [127:96] = counter2
    - flag == 1 (PING) or 2 (ACK_PING) -> DELIVER; otherwise drop, rx_drop_cnt+1 -> IDLE.
  - DELIVER: wait for consumer_idle = 1. In that cycle, update recv_seq/sec/counter2 and assert the matching pulse for exactly one cycle; increment the matching counter -> IDLE.
- Output holds: recv_seq/sec/counter2 hold until the next delivery; recv_ping and recv_ack_ping are never asserted together.
- Counters saturate at 16'hFFFF.
- Latency: rx_done into an empty queue in IDLE -> ipic_start asserted 2 cycles later. ipic_done_wire -> pulse 2 cycles later when consumer_idle is already high.
- Ordering: one outstanding burst at a time; frames are delivered in arrival order.

Decomposition:
- Shared package tdma_pkg holds:
  - IPIC type codes BURST_RD/BURST_WR/SINGLE_RD/SINGLE_WR.
  - Ping flags PING = 1, ACK_PING = 2.
  - MAX_COUNTER2 = 32'hf4239.
  - Payload word indices.
- The transmit side uses the same package.
- One sub-module: tdma_sync_fifo (parameterised width/depth, first-word-fall-through, full/empty) for the pending RX event queue.

Test Plan:
- PING decode: rx_done addr 0x1000_0000, len 200; ack after 1 cycle; done with data {32'h000A1234, 32'h5B8D_0000, 32'h7, 32'h1}. Required: read_addr = 0x1000_0050, read_length = 16; recv_ping pulses 1 cycle; seq = 7, sec = 0x5B8D0000, counter2 = 0xA1234; rx_ping_cnt = 1.
- ACK_PING with consumer_idle low for 10 cycles. Required: no pulse until consumer_idle rises, then recv_ack_ping for 1 cycle; rx_ack_cnt = 1.
- Short frame len = 90, then flag = 3 frame. Required: no IPIC request for the first frame; no pulse for the second; rx_drop_cnt = 2.
- Six back-to-back rx_done while the first burst is stalled (no ipic_ack for 50 cycles). Required: 4 queued and 1 in service delivered in order; 1 dropped; rx_drop_cnt = 1.
- Reset asserted in WAIT, then ipic_done_wire pulse. Required: all outputs 0, no pulse, counters 0, next rx_done serviced normally.
